// File: rtl/bpu_pkg.sv
// Shared video/palette constants and the framebuffer-writer FSM state type.
package bpu_pkg;

  localparam int VIDEO_WIDTH           = 640;
  localparam int VIDEO_HEIGHT          = 480;
  localparam int PIXEL_COUNT           = VIDEO_WIDTH * VIDEO_HEIGHT;
  localparam int PIXEL_ADDRESS_WIDTH   = 20;
  localparam int PALETTE_ADDRESS_WIDTH = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_ERASE = 2'd2,
    ST_DRAW  = 2'd3
  } fsm_state_t;

  // x + 640*y built from shifts: 640 = 512 + 128.
  function automatic logic [PIXEL_ADDRESS_WIDTH-1:0] pixel_addr(input logic [9:0] x,
                                                                input logic [8:0] y);
    logic [PIXEL_ADDRESS_WIDTH-1:0] yy;
    yy = {11'd0, y};
    return {10'd0, x} + (yy << 9) + (yy << 7);
  endfunction

endpackage

// File: rtl/boid_addr_table.sv
// Per-boid last-drawn pixel address with valid bits: one async read, one write, clear-all.
module boid_addr_table
  import bpu_pkg::*;
#(
  parameter int NUM_BOIDS = 16,
  parameter int ID_W      = $clog2(NUM_BOIDS)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [ID_W-1:0]                rd_id_i,
  output logic [PIXEL_ADDRESS_WIDTH-1:0] rd_addr_o,
  output logic                           rd_valid_o,
  input  logic                           we_i,
  input  logic [ID_W-1:0]                wr_id_i,
  input  logic [PIXEL_ADDRESS_WIDTH-1:0] wr_addr_i,
  input  logic                           clr_all_i
);

  logic [PIXEL_ADDRESS_WIDTH-1:0] addr_q [NUM_BOIDS];
  logic [NUM_BOIDS-1:0]           valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_all_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_id_i] <= 1'b1;
    end
  end

  // Address storage needs no reset; the valid bits qualify it.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      addr_q[wr_id_i] <= wr_addr_i;
    end
  end

  assign rd_addr_o  = addr_q[rd_id_i];
  assign rd_valid_o = valid_q[rd_id_i];

endmodule

// File: rtl/boid_fb_writer.sv
// Boid framebuffer writer: erases a boid's previous pixel, draws the new one, and clears the frame.
// Build option BOID_TRAIL_EN: never erase, leaving trails.
module boid_fb_writer
  import bpu_pkg::*;
#(
  parameter int         NUM_BOIDS    = 16,
  parameter logic [8:0] BOID_COLOR   = 9'd1,
  parameter logic [8:0] BG_COLOR     = 9'd0,
  parameter int         CLEAR_PIXELS = PIXEL_COUNT,
  localparam int        ID_W         = $clog2(NUM_BOIDS)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [9:0]                       req_x,
  input  logic [8:0]                       req_y,
  input  logic [ID_W-1:0]                  req_id,
  input  logic                             clear_start,
  output logic                             busy,
  output logic                             fb_we,
  output logic [PIXEL_ADDRESS_WIDTH-1:0]   fb_addr,
  output logic [PALETTE_ADDRESS_WIDTH-1:0] fb_data,
  output logic [7:0]                       drop_count,
  output fsm_state_t                       dbg_state
);

  fsm_state_t                     state_q, state_d;
  logic [PIXEL_ADDRESS_WIDTH-1:0] new_addr_q, old_addr_q, clr_cnt_q;
  logic [ID_W-1:0]                id_q;
  logic [7:0]                     drop_q;

  logic [PIXEL_ADDRESS_WIDTH-1:0] tbl_rd_addr;
  logic                           tbl_rd_valid, tbl_we, tbl_clr;
  logic                           in_range, req_seen, take_req, drop_req, need_erase, clr_last;

  assign req_ready  = (state_q == ST_IDLE) && !reset;
  // clear_start wins over a simultaneous request, which is then not taken.
  assign req_seen   = (state_q == ST_IDLE) && req_valid && !clear_start;
  assign in_range   = (req_x < 10'(VIDEO_WIDTH)) && (req_y < 9'(VIDEO_HEIGHT));
  assign take_req   = req_seen && in_range;
  assign drop_req   = req_seen && !in_range;
  assign clr_last   = (clr_cnt_q == PIXEL_ADDRESS_WIDTH'(CLEAR_PIXELS - 1));
`ifdef BOID_TRAIL_EN
  assign need_erase = 1'b0;
`else
  assign need_erase = tbl_rd_valid;
`endif

  boid_addr_table #(.NUM_BOIDS(NUM_BOIDS), .ID_W(ID_W)) u_table (
    .clk_i      (clock),
    .rst_i      (reset),
    .rd_id_i    (req_id),
    .rd_addr_o  (tbl_rd_addr),
    .rd_valid_o (tbl_rd_valid),
    .we_i       (tbl_we),
    .wr_id_i    (id_q),
    .wr_addr_i  (new_addr_q),
    .clr_all_i  (tbl_clr)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      new_addr_q <= '0;
      old_addr_q <= '0;
      id_q       <= '0;
      clr_cnt_q  <= '0;
      drop_q     <= '0;
    end else begin
      state_q <= state_d;
      if (take_req) begin
        new_addr_q <= pixel_addr(req_x, req_y);
        old_addr_q <= tbl_rd_addr;
        id_q       <= req_id;
      end
      if (drop_req && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end
      clr_cnt_q <= (state_q == ST_CLEAR) ? clr_cnt_q + 1'b1 : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_start)   state_d = ST_CLEAR;
        else if (take_req) state_d = need_erase ? ST_ERASE : ST_DRAW;
      end
      ST_CLEAR: if (clr_last) state_d = ST_IDLE;
      ST_ERASE: state_d = ST_DRAW;
      ST_DRAW:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fb_we   = 1'b0;
    fb_addr = '0;
    fb_data = '0;
    tbl_we  = 1'b0;
    tbl_clr = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        fb_we   = 1'b1;
        fb_addr = clr_cnt_q;
        fb_data = BG_COLOR;
        tbl_clr = clr_last;
      end
      ST_ERASE: begin
        fb_we   = 1'b1;
        fb_addr = old_addr_q;
        fb_data = BG_COLOR;
      end
      ST_DRAW: begin
        fb_we   = 1'b1;
        fb_addr = new_addr_q;
        fb_data = BOID_COLOR;
        tbl_we  = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign drop_count = drop_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_boid_fb_writer.sv
// Directed bench for boid_fb_writer; frame clear is shortened to 64 pixels to keep runs short.
module tb_boid_fb_writer;
  import bpu_pkg::*;

  localparam int CLR_N = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [9:0]  req_x = '0;
  logic [8:0]  req_y = '0;
  logic [3:0]  req_id = '0;
  logic        clear_start = 1'b0;
  logic        busy, fb_we;
  logic [19:0] fb_addr;
  logic [8:0]  fb_data;
  logic [7:0]  drop_count;
  fsm_state_t  dbg_state;

  int n_total = 0;
  int n_pass  = 0;
  int we_seen;

  always #10 clock = ~clock;

  boid_fb_writer #(.CLEAR_PIXELS(CLR_N)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_id      (req_id),
    .clear_start (clear_start),
    .busy        (busy),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .drop_count  (drop_count),
    .dbg_state   (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Present one request for a single handshake edge; returns at the next negedge.
  task automatic req_pulse(input logic [9:0] x, input logic [8:0] y, input logic [3:0] id);
    req_valid = 1'b1;
    req_x     = x;
    req_y     = y;
    req_id    = id;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic exp_write(input string tag, input logic [19:0] addr, input logic [8:0] data);
    chk({tag, "_we"},   32'(fb_we),   32'd1);
    chk({tag, "_addr"}, 32'(fb_addr), 32'(addr));
    chk({tag, "_data"}, 32'(fb_data), 32'(data));
    @(negedge clock);
  endtask

  task automatic exp_idle(input string tag);
    chk({tag, "_we"},    32'(fb_we),     32'd0);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_busy"},  32'(busy),      32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_we",    32'(fb_we),     32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    reset = 1'b0;
    @(negedge clock);
    exp_idle("post_rst");
    chk("post_rst_addr",  32'(fb_addr),    32'd0);
    chk("post_rst_data",  32'(fb_data),    32'd0);
    chk("post_rst_drop",  32'(drop_count), 32'd0);
    chk("post_rst_state", 32'(dbg_state),  32'(ST_IDLE));

    // First draw of slot 0: no erase, one cycle after handshake.
    req_pulse(10'd10, 9'd10, 4'd0);
    chk("draw0_state", 32'(dbg_state), 32'(ST_DRAW));
    exp_write("draw0", 20'd6410, 9'd1);
    exp_idle("draw0_done");

    // Move slot 0: erase old then draw new.
    req_pulse(10'd11, 9'd10, 4'd0);
`ifndef BOID_TRAIL_EN
    exp_write("erase1", 20'd6410, 9'd0);
`endif
    exp_write("draw1", 20'd6411, 9'd1);
    exp_idle("move_done");

    // Same position again: still erase then draw.
    req_pulse(10'd11, 9'd10, 4'd0);
`ifndef BOID_TRAIL_EN
    exp_write("erase_same", 20'd6411, 9'd0);
`endif
    exp_write("draw_same", 20'd6411, 9'd1);
    exp_idle("same_done");

    // clear_start during ERASE/DRAW is ignored.
    req_pulse(10'd20, 9'd20, 4'd0);
    clear_start = 1'b1;
`ifndef BOID_TRAIL_EN
    exp_write("erase_clrign", 20'd6411, 9'd0);
`endif
    exp_write("draw_clrign", 20'd12820, 9'd1);
    clear_start = 1'b0;
    exp_idle("clrign_done");

    // Out-of-range requests are dropped.
    req_pulse(10'd640, 9'd0, 4'd1);
    exp_idle("drop_x");
    chk("drop_x_cnt", 32'(drop_count), 32'd1);
    req_pulse(10'd0, 9'd480, 4'd1);
    exp_idle("drop_y");
    chk("drop_y_cnt", 32'(drop_count), 32'd2);
    // Slot 1 untouched by drops: first valid request draws directly.
    req_pulse(10'd0, 9'd0, 4'd1);
    exp_write("draw_slot1", 20'd0, 9'd1);
    exp_idle("slot1_done");

    // 298 more drops back to back; count saturates at 255.
    we_seen   = 0;
    req_valid = 1'b1;
    req_x     = 10'd700;
    req_y     = 9'd100;
    req_id    = 4'd2;
    for (int i = 0; i < 298; i++) begin
      @(negedge clock);
      if (fb_we) we_seen++;
    end
    req_valid = 1'b0;
    @(negedge clock);
    chk("drop_sat_we",  32'(we_seen),    32'd0);
    chk("drop_sat_cnt", 32'(drop_count), 32'd255);

    // Clear has priority over a simultaneous request.
    clear_start = 1'b1;
    req_pulse(10'd5, 9'd5, 4'd2);
    clear_start = 1'b0;
    chk("clr_state", 32'(dbg_state), 32'(ST_CLEAR));
    chk("clr_ready", 32'(req_ready), 32'd0);
    we_seen = 0;
    for (int i = 0; i < CLR_N; i++) begin
      if (fb_we === 1'b1 && fb_addr === 20'(i) && fb_data === 9'd0) we_seen++;
      @(negedge clock);
    end
    chk("clr_writes", 32'(we_seen), 32'(CLR_N));
    exp_idle("clr_done");
    chk("clr_drop_kept", 32'(drop_count), 32'd255);

    // Slots were invalidated: slot 0 draws without erase.
    req_pulse(10'd10, 9'd10, 4'd0);
    exp_write("post_clr_draw", 20'd6410, 9'd1);
    exp_idle("post_clr_done");

    // Reset two cycles into a clear aborts it.
    clear_start = 1'b1;
    @(negedge clock);
    clear_start = 1'b0;
    chk("clr2_w0", 32'(fb_addr), 32'd0);
    @(negedge clock);
    chk("clr2_w1", 32'(fb_addr), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_we",    32'(fb_we),      32'd0);
    chk("abort_addr",  32'(fb_addr),    32'd0);
    chk("abort_data",  32'(fb_data),    32'd0);
    chk("abort_busy",  32'(busy),       32'd0);
    chk("abort_drop",  32'(drop_count), 32'd0);
    chk("abort_ready", 32'(req_ready),  32'd0);
    reset = 1'b0;
    @(negedge clock);
    exp_idle("abort_after");
    req_pulse(10'd10, 9'd10, 4'd0);
    exp_write("abort_draw", 20'd6410, 9'd1);
    exp_idle("abort_done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/boid_fb_writer.md
BOID_FB_WRITER -- requirements
Module: boid_fb_writer

Interface
REQ-001 Parameter NUM_BOIDS, default 16: boid slots tracked; req_id width = $clog2(NUM_BOIDS).
REQ-002 Parameter BOID_COLOR, default 9'd1: palette index drawn at a boid pixel.
REQ-003 Parameter BG_COLOR, default 9'd0: palette index for erase and clear.
REQ-004 clock  in  1  50 MHz system clock; one clock; all logic on posedge clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  position request present.
REQ-007 req_ready  out  1  block can accept a request this cycle.
REQ-008 req_x  in  10  boid x, valid range 0..639.
REQ-009 req_y  in  9  boid y, valid range 0..479.
REQ-010 req_id  in  $clog2(NUM_BOIDS)  boid slot index.
REQ-011 clear_start  in  1  single-cycle pulse requesting full-frame clear.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 fb_we  out  1  framebuffer write strobe.
REQ-014 fb_addr  out  20  pixel address (PIXEL_ADDRESS_WIDTH).
REQ-015 fb_data  out  9  palette index (PALETTE_ADDRESS_WIDTH).
REQ-016 drop_count  out  8  count of out-of-range requests, saturating.

Function
REQ-017 FSM states SHALL be exactly IDLE, CLEAR, ERASE, DRAW.
REQ-018 req_ready SHALL equal (state==IDLE) and SHALL be 0 during the cycle reset is high.
REQ-019 Handshake SHALL complete on a posedge where req_valid and req_ready are both 1; req_x/req_y/req_id are captured on that edge.
REQ-020 Address SHALL be computed as x + (y<<9) + (y<<7), 20 bits, no multiplier, and registered at capture.
REQ-021 If captured x>=640 or y>=480, the block SHALL drop the request: no write, table unchanged, drop_count+1 (held at 255), and remain in IDLE.
REQ-022 If the valid request's slot holds a valid old address, the next state SHALL be ERASE; otherwise it SHALL be DRAW.
REQ-023 In ERASE: fb_we=1, fb_addr=old address, fb_data=BG_COLOR, for one cycle; then DRAW.
REQ-024 In DRAW: fb_we=1, fb_addr=new address, fb_data=BOID_COLOR, for one cycle; the slot stores the new address and is marked valid; then IDLE.
REQ-025 Latency: the DRAW write SHALL appear 1 cycle after the handshake edge (no old entry) or 2 cycles after it (with erase).
REQ-026 fb_we SHALL be 0 in IDLE.
REQ-027 clear_start in IDLE SHALL take priority over a simultaneous req_valid; that request is not accepted.
REQ-028 CLEAR SHALL write BG_COLOR to addresses 0..307199, one per cycle, ascending, then invalidate all slots and return to IDLE (307200 write cycles).
REQ-029 clear_start outside IDLE SHALL be ignored.
REQ-030 An old address equal to the new address SHALL still produce both ERASE and DRAW writes, in that order.

Reset
REQ-031 On reset: state=IDLE, fb_we=0, fb_addr=0, fb_data=0, drop_count=0, busy=0, all slots invalid.
REQ-032 Reset asserted mid-ERASE/DRAW/CLEAR SHALL abort on that edge with no further writes; a partial clear is not resumed.

Configuration
REQ-033 Macro BOID_TRAIL_EN: when defined, ERASE is never entered; every accepted in-range request goes straight to DRAW, leaving trails, and the slot is still updated.
REQ-034 Without BOID_TRAIL_EN: behaviour per REQ-022..REQ-025.

Structure
REQ-035 Shared package bpu_pkg SHALL hold VIDEO_WIDTH, VIDEO_HEIGHT, PIXEL_COUNT, PIXEL_ADDRESS_WIDTH, PALETTE_ADDRESS_WIDTH and the FSM state typedef.
REQ-036 Sub-module boid_addr_table SHALL hold NUM_BOIDS x 20-bit addresses plus valid bits, with one read port, one write port and a clear-all input.

Verification
REQ-037 Request (x=10,y=10,id=0) after reset -> one write 1 cycle later: addr 6410, data 1; no erase.
REQ-038 Then (x=11,y=10,id=0) -> erase addr 6410 data 0, next cycle draw addr 6411 data 1.
REQ-039 Request (x=640,y=0) then (x=0,y=480) -> no fb_we, drop_count=2; with 300 such requests -> drop_count=255.
REQ-040 clear_start together with req_valid in IDLE -> req not accepted; 307200 writes, addresses 0..307199, data 0; next id=0 request draws without erase.
REQ-041 Reset asserted 2 cycles into CLEAR -> fb_we=0 next cycle, all outputs at reset values, req_ready=1 the cycle after reset deasserts.
REQ-042 With BOID_TRAIL_EN, REQ-038 stimulus -> only draw writes (6410, 6411), no erase.
